int_ack_responder: RTL and testbench

Responder side of the Z80 interrupt protocol. It collects interrupt requests from three on-board sources and drives an active-low INT request. It answers the CPU's interrupt-acknowledge cycle (M1+IORQ) with an IM2 vector byte. It tracks in-service nesting and clears it on a decoded RETI, in the same way as a Z80 daisy-chain peripheral. It sits beside cpucontrol on the cpu_bus. Its n_int_ext output is ANDed with the frame INT at the top level.

---
 rtl/int_ack_responder_pkg.sv | 38 +++
 rtl/int_ack_responder_if.sv | 14 +
 rtl/int_ack_responder_reti_detector.sv | 78 +++++++
 rtl/int_ack_responder.sv | 99 +++++++++
 tb/tb_int_ack_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_ack_responder_pkg.sv
// Purpose: shared types, opcodes and helpers for the Z80 interrupt-acknowledge responder.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package int_ack_responder_pkg;

  // Source index doubles as the vector offset; NONE encodes the spurious-INTA vector.
  typedef enum logic [1:0] {
    INT_SRC_LINE  = 2'd0,
    INT_SRC_FRAME = 2'd1,
    INT_SRC_EXT   = 2'd2,
    INT_SRC_NONE  = 2'd3
  } int_src_t;

  typedef enum logic {
    IDLE   = 1'b0,
    GOT_ED = 1'b1
  } reti_state_t;

  localparam logic [7:0] OPC_ED    = 8'hED;
  localparam logic [7:0] OPC_RETI2 = 8'h4D;

  // A source may interrupt only when nothing of equal or higher priority is in service.
  function automatic logic [2:0] eligible_f(input logic [2:0] pend,
                                            input logic [2:0] en,
                                            input logic [2:0] insvc);
    logic [2:0] e;
    e[0] = pend[0] & en[0] & ~insvc[0];
    e[1] = pend[1] & en[1] & ~(|insvc[1:0]);
    e[2] = pend[2] & en[2] & ~(|insvc[2:0]);
    return e;
  endfunction

  // Isolates the lowest-index set bit (the most recently nested, highest-priority service).
  function automatic logic [2:0] lowest_set_f(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/int_ack_responder_if.sv
// Purpose: Z80 CPU bus strobes and data seen by on-board peripherals.
// Latency: n/a (wires only).
// Backpressure: none; the CPU owns the bus timing.
// Signals: m1, iorq, mreq, rd (active-high strobes), d[7:0] data bus.
interface cpu_bus;
  logic       m1;
  logic       iorq;
  logic       mreq;
  logic       rd;
  logic [7:0] d;

  modport master (output m1, iorq, mreq, rd, d);
  modport slave  (input  m1, iorq, mreq, rd, d);
endinterface

// File: rtl/int_ack_responder_reti_detector.sv
// Purpose: watches opcode fetches and flags a completed ED 4D (RETI) sequence.
// Latency: reti_pulse one clk28 after the falling edge of the M1 that fetched 4D.
// Backpressure: none; pure observer of the bus.
// Ports: clk28, rst_n, m1/mreq/rd/iorq strobes, d[7:0] data bus -> reti_pulse (1 clk28).
module reti_detector
  import int_ack_responder_pkg::*;
(
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       m1,
  input  logic       mreq,
  input  logic       rd,
  input  logic       iorq,
  input  logic [7:0] d,
  output logic       reti_pulse
);

  reti_state_t state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic        m1_prev_q, m1_prev_d;
  logic        was_inta_q, was_inta_d;
  logic        reti_pulse_q, reti_pulse_d;
  logic        m1_fall;

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    m1_prev_d    = m1;
    // Remembers whether the current M1 is an interrupt acknowledge; cleared once M1 ends.
    was_inta_d   = m1 & (was_inta_q | iorq);
    reti_pulse_d = 1'b0;
    m1_fall      = m1_prev_q & ~m1;

    if (m1 && mreq && rd) begin
      opc_d = d;
    end

    if (m1 && iorq) begin
      state_d = IDLE;
    end else if (m1_fall && !was_inta_q) begin
      case (state_q)
        IDLE: begin
          state_d = (opc_q == OPC_ED) ? GOT_ED : IDLE;
        end
        GOT_ED: begin
          if (opc_q == OPC_RETI2) begin
            reti_pulse_d = 1'b1;
            state_d      = IDLE;
          end else if (opc_q == OPC_ED) begin
            state_d = GOT_ED;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opc_q        <= 8'h00;
      m1_prev_q    <= 1'b0;
      was_inta_q   <= 1'b0;
      reti_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      m1_prev_q    <= m1_prev_d;
      was_inta_q   <= was_inta_d;
      reti_pulse_q <= reti_pulse_d;
    end
  end

  assign reti_pulse = reti_pulse_q;

endmodule

// File: rtl/int_ack_responder.sv
// Purpose: Z80 IM2 interrupt responder: pends 3 sources, drives n_int_ext, answers INTA with a vector, nests via RETI.
// Latency: n_int_ext 1 clk28 after pending/in-service change; vector and d_oe 1 clk28 after INTA rises.
// Backpressure: none; requests are sticky until acknowledged, the CPU paces everything.
// Ports: clk28, rst_n, bus (cpu_bus.slave), int_req/int_en[2:0] -> n_int_ext, d_out[7:0], d_oe, in_service[2:0].
module int_ack_responder
  import int_ack_responder_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'hF8,
  parameter int         SRC_N       = 3
)(
  input  logic             clk28,
  input  logic             rst_n,
  cpu_bus.slave            bus,
  input  logic [SRC_N-1:0] int_req,
  input  logic [SRC_N-1:0] int_en,
  output logic             n_int_ext,
  output logic [7:0]       d_out,
  output logic             d_oe,
  output logic [SRC_N-1:0] in_service
);

  logic [2:0] pending_q, pending_d;
  logic [2:0] in_service_q, in_service_d;
  logic       n_int_ext_q, n_int_ext_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       inta_prev_q, inta_prev_d;

  logic       reti_pulse;
  logic       inta, inta_rise;
  logic [2:0] in_service_eff;
  logic [2:0] elig_now, elig_inta;
  logic [2:0] grant;
  int_src_t   winner;

  reti_detector u_reti (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .m1         (bus.m1),
    .mreq       (bus.mreq),
    .rd         (bus.rd),
    .iorq       (bus.iorq),
    .d          (bus.d),
    .reti_pulse (reti_pulse)
  );

  always_comb begin
    inta        = bus.m1 & bus.iorq;
    inta_rise   = inta & ~inta_prev_q;
    inta_prev_d = inta;

    // A RETI landing in the same cycle as an INTA edge is retired before arbitration.
    in_service_eff = reti_pulse ? (in_service_q & ~lowest_set_f(in_service_q)) : in_service_q;

    elig_now  = eligible_f(pending_q, int_en, in_service_q);
    elig_inta = eligible_f(pending_q, int_en, in_service_eff);

    if (elig_inta[0])      winner = INT_SRC_LINE;
    else if (elig_inta[1]) winner = INT_SRC_FRAME;
    else if (elig_inta[2]) winner = INT_SRC_EXT;
    else                   winner = INT_SRC_NONE;

    grant = 3'b000;
    if (inta_rise && (winner != INT_SRC_NONE)) begin
      grant = 3'b001 << winner;
    end

    // New requests are OR'd in after the acknowledge clear, so a coincident set wins.
    pending_d    = (pending_q & ~grant) | int_req;
    in_service_d = in_service_eff | grant;
    n_int_ext_d  = ~(|elig_now);
    d_out_d      = inta_rise ? {VECTOR_BASE[7:3], winner, 1'b0} : d_out_q;
    d_oe_d       = inta;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= 3'b000;
      in_service_q <= 3'b000;
      n_int_ext_q  <= 1'b1;
      d_out_q      <= 8'hFF;
      d_oe_q       <= 1'b0;
      inta_prev_q  <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      n_int_ext_q  <= n_int_ext_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      inta_prev_q  <= inta_prev_d;
    end
  end

  assign n_int_ext  = n_int_ext_q;
  assign d_out      = d_out_q;
  assign d_oe       = d_oe_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_ack_responder.sv
// Purpose: randomized scoreboard bench for int_ack_responder against a sequence-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_int_ack_responder;

  logic       clk28;
  logic       rst_n;
  logic [2:0] int_req;
  logic [2:0] int_en;
  logic       n_int_ext;
  logic [7:0] d_out;
  logic       d_oe;
  logic [2:0] in_service;

  cpu_bus bus_if();

  int_ack_responder #(.VECTOR_BASE(8'hF8), .SRC_N(3)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .int_req    (int_req),
    .int_en     (int_en),
    .n_int_ext  (n_int_ext),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .in_service (in_service)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] vec;
    logic [2:0] isv;
  } exp_t;
  exp_t exp_q[$];
  int   pushed = 0;
  int   popped = 0;

  // Reference state: what is pending, what is in service, last fetched opcode.
  bit [2:0] m_pend;
  bit [2:0] m_insvc;
  bit [7:0] m_last_op;
  int       m_reti;
  int       reti_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] model_elig();
    bit [2:0] e;
    for (int i = 0; i < 3; i++) begin
      bit blocked;
      blocked = 1'b0;
      for (int j = 0; j <= i; j++) if (m_insvc[j]) blocked = 1'b1;
      e[i] = m_pend[i] && int_en[i] && !blocked;
    end
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic check_nint(input string name);
    chk(name, {31'd0, n_int_ext}, {31'd0, ~(|model_elig())});
  endtask

  task automatic pulse_req(input bit [2:0] mask);
    int_req = mask;
    cyc(1);
    int_req = 3'b000;
    m_pend  = m_pend | mask;
    cyc(1);
    check_nint("n_int_ext_after_req");
  endtask

  // Expected vector computed as base + 2*winner, winner = first eligible index or 3.
  task automatic model_inta(input bit [2:0] req_mask);
    bit [2:0] e;
    int       w;
    exp_t     x;
    e = model_elig();
    w = 3;
    for (int i = 2; i >= 0; i--) if (e[i]) w = i;
    if (w != 3) begin
      m_pend[w]  = 1'b0;
      m_insvc[w] = 1'b1;
    end
    m_pend    = m_pend | req_mask;
    m_last_op = 8'h00;
    x.vec = 8'hF8 + 8'(2 * w);
    x.isv = m_insvc;
    exp_q.push_back(x);
    pushed++;
  endtask

  task automatic inta_cycle(input bit [2:0] req_mask);
    bus_if.m1 = 1'b1;
    cyc(1);
    bus_if.iorq = 1'b1;
    int_req     = req_mask;
    model_inta(req_mask);
    cyc(1);
    int_req = 3'b000;
    cyc(2);
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b0;
    cyc(2);
    chk("d_oe_after_inta", {31'd0, d_oe}, 32'd0);
    check_nint("n_int_ext_after_inta");
  endtask

  task automatic fetch(input bit [7:0] op);
    bus_if.m1   = 1'b1;
    bus_if.mreq = 1'b1;
    bus_if.rd   = 1'b1;
    bus_if.d    = op;
    cyc(2);
    bus_if.m1   = 1'b0;
    bus_if.mreq = 1'b0;
    bus_if.rd   = 1'b0;
    if (op == 8'h4D && m_last_op == 8'hED) begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3; i++) if (m_insvc[i] && !done) begin
        m_insvc[i] = 1'b0;
        done = 1'b1;
      end
      m_reti++;
    end
    m_last_op = op;
    cyc(3);
    chk("in_service_after_fetch", {29'd0, in_service}, {29'd0, m_insvc});
    check_nint("n_int_ext_after_fetch");
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  task automatic model_reset();
    m_pend    = 3'b000;
    m_insvc   = 3'b000;
    m_last_op = 8'h00;
  endtask

  always @(posedge clk28) if (dut.u_reti.reti_pulse) reti_seen++;

  // Monitor: every new d_oe assertion must match the oldest expected acknowledge.
  initial begin
    logic oe_prev;
    exp_t x;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk28);
      if (d_oe && !oe_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inta_response", {31'd0, d_oe}, 32'd0);
        end else begin
          x = exp_q.pop_front();
          popped++;
          chk("inta_vector", {24'd0, d_out}, {24'd0, x.vec});
          chk("inta_in_service", {29'd0, in_service}, {29'd0, x.isv});
        end
      end
      oe_prev = d_oe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int base;
    rst_n       = 1'b0;
    int_req     = 3'b000;
    int_en      = 3'b111;
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b0;
    bus_if.mreq = 1'b0;
    bus_if.rd   = 1'b0;
    bus_if.d    = 8'h00;
    model_reset();
    m_reti = 0;
    cyc(2);
    chk("reset_n_int_ext", {31'd0, n_int_ext}, 32'd1);
    chk("reset_d_out", {24'd0, d_out}, 32'h0000_00FF);
    chk("reset_d_oe", {31'd0, d_oe}, 32'd0);
    chk("reset_in_service", {29'd0, in_service}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Single ext source: vector FC, then INT released.
    pulse_req(3'b100);
    inta_cycle(3'b000);
    chk("ext_in_service", {29'd0, in_service}, 32'd4);
    reti();

    // Simultaneous line+frame: line first, frame blocked until RETI.
    pulse_req(3'b011);
    inta_cycle(3'b000);
    chk("frame_blocked_nint", {31'd0, n_int_ext}, 32'd1);
    reti();
    chk("frame_unblocked_nint", {31'd0, n_int_ext}, 32'd0);
    inta_cycle(3'b000);
    reti();

    // Nesting: line interrupts an ext service.
    pulse_req(3'b100);
    inta_cycle(3'b000);
    pulse_req(3'b001);
    chk("nest_nint", {31'd0, n_int_ext}, 32'd0);
    inta_cycle(3'b000);
    chk("nest_in_service", {29'd0, in_service}, 32'd5);
    reti();
    chk("nest_after_reti", {29'd0, in_service}, 32'd4);
    reti();

    // RETI decode sequences.
    base = reti_seen;
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    chk("reti_ed_ed_4d", base + 1, reti_seen);
    base = reti_seen;
    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    chk("reti_ed_00_4d", base, reti_seen);

    // Spurious INTA with a masked pending source; unmasking restores it.
    int_en = 3'b110;
    pulse_req(3'b001);
    inta_cycle(3'b000);
    chk("spurious_d_out", {24'd0, d_out}, 32'h0000_00FE);
    int_en = 3'b111;
    cyc(2);
    check_nint("unmask_nint");

    // Request coinciding with its own acknowledge stays pending.
    inta_cycle(3'b001);
    reti();
    chk("set_wins_nint", {31'd0, n_int_ext}, 32'd0);
    inta_cycle(3'b000);
    reti();

    // Asynchronous reset while the vector is on the bus.
    pulse_req(3'b010);
    bus_if.m1 = 1'b1;
    cyc(1);
    bus_if.iorq = 1'b1;
    model_inta(3'b000);
    cyc(1);
    @(negedge clk28);
    #1;
    chk("pre_reset_d_oe", {31'd0, d_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_d_oe", {31'd0, d_oe}, 32'd0);
    chk("async_reset_in_service", {29'd0, in_service}, 32'd0);
    chk("async_reset_n_int_ext", {31'd0, n_int_ext}, 32'd1);
    bus_if.m1   = 1'b0;
    bus_if.iorq = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Randomized mix of requests, mask changes, acknowledges and fetches.
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: pulse_req(3'($urandom_range(1, 7)));
        3: begin
          int_en = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
          cyc(2);
          check_nint("n_int_ext_after_en");
        end
        4, 5: inta_cycle(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        6, 7: reti();
        8: begin
          int s;
          s = $urandom_range(0, 3);
          fetch(s == 0 ? 8'hED : s == 1 ? 8'h4D : s == 2 ? 8'h00 : 8'($urandom_range(0, 255)));
        end
        default: fetch(8'hED);
      endcase
    end

    cyc(4);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("responses_seen", popped, pushed);
    chk("reti_pulse_count", reti_seen, m_reti);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
